netlist_vector_player: RTL and testbench
========================================

// Module: netlist_vector_player
// PURPOSE
//   Sequential driver/capture end for the mapped combinational core netlists (14-in/8-out
//   class). Accepts stimulus vectors over a valid/ready stream and drives them onto the
//   core inputs. Waits a settle window, then samples the core outputs and compares them
//   against an expected word under a mask. Returns per-vector results on a second stream
//   and keeps pass/fail tallies. Sits between the on-chip vector source and the
//   combinational core under evaluation.
// PARAMETERS
//   IN_W        14  core input width (stimulus width)
//   OUT_W       8   core output width (response/expect/mask width)
//   SETTLE_CYC  2   cycles core_in is held before core_out is sampled; 0 is legal
//   CNT_W       16  width of m_idx, pass_cnt and fail_cnt
// PORTS
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   s_valid     in   1       stimulus vector valid
//   s_ready     out  1       block can accept a vector (high only in IDLE)
//   s_stim      in   IN_W    stimulus word
//   s_expect    in   OUT_W   expected core response
//   s_mask      in   OUT_W   1 = compare this bit
//   core_in     out  IN_W    registered drive to the core inputs
//   core_out    in   OUT_W   core outputs (combinational from core_in)
//   m_valid     out  1       result valid
//   m_ready     in   1       result consumer ready
//   m_resp      out  OUT_W   captured core_out
//   m_mismatch  out  1       |((m_resp ^ expect) & mask)
//   m_idx       out  CNT_W   sequence number of this result, starts at 0
//   pass_cnt    out  CNT_W   results delivered with m_mismatch=0 (saturating)
//   fail_cnt    out  CNT_W   results delivered with m_mismatch=1 (saturating)
//   clear       in   1       synchronous clear of m_idx, pass_cnt and fail_cnt
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - state=IDLE; core_in, m_resp, m_idx, pass_cnt and fail_cnt all 0.
//   - m_valid=0, m_mismatch=0, and s_ready=1 once rst_n deasserts.
//   FSM states:
//   - IDLE: s_ready=1. On s_valid&s_ready at edge E0, register s_stim->core_in and latch
//     expect/mask. Load the settle counter with SETTLE_CYC. Go to DRIVE.
//   - DRIVE: s_ready=0. If cnt!=0, decrement. If cnt==0, then on that edge:
//     m_resp<=core_out; m_mismatch<=|((core_out^exp)&mask); m_valid<=1; go to REPORT.
//     This puts m_valid high after edge E0+SETTLE_CYC+1.
//   - REPORT: m_valid=1. m_resp, m_mismatch and m_idx are held stable until m_ready=1.
//     On the handshake edge: m_valid<=0; m_idx++ (wraps at 2^CNT_W); pass_cnt or
//     fail_cnt ++, saturating at all-ones; go to IDLE.
//   - The next vector can be accepted no earlier than the cycle after the handshake.
//     Peak throughput is 1 vector per SETTLE_CYC+3 cycles.
//   core_in:
//   - Changes only on an accept edge.
//   - Holds the last stimulus in IDLE so the core never sees spurious transitions.
//   clear:
//   - Zeroes m_idx, pass_cnt and fail_cnt. It does not touch the FSM, so an in-flight
//     vector completes normally.
//   - clear coincident with a REPORT handshake: clear wins. All three are 0 after the
//     edge, and the completing result is not counted.
//   Protocol:
//   - s_valid is ignored outside IDLE; the source must hold the vector until s_ready.
//   - m_ready is ignored outside REPORT.
//   Reset mid-operation:
//   - The in-flight vector is dropped, with no partial result and no counter update.
//   - core_in returns to 0.
//   Width: all counters are unsigned. mask=0 forces m_mismatch=0.
// TESTING (bench stubs the core as core_out = core_in[7:0] ^ 8'hA5; defaults except noted)
//   1. Latency: accept s_stim=14'h0012, expect=8'hB7, mask=8'hFF at edge E0.
//      -> m_valid rises after E0+3, m_resp=8'hB7, m_mismatch=0.
//      -> After handshake: pass_cnt=1, m_idx=1.
//   2. Mask: same stim with expect=8'hB6. mask=8'hFF -> m_mismatch=1, fail_cnt=1.
//      Repeat with mask=8'hFE -> m_mismatch=0.
//   3. Backpressure: hold m_ready=0 for 5 cycles in REPORT.
//      -> m_valid, m_resp and m_idx stay stable; s_ready=0 throughout.
//      -> Single count on release.
//   4. Saturation/wrap: CNT_W=4, 17 passing vectors.
//      -> pass_cnt=4'hF, m_idx of the 17th result=0.
//      -> clear on the 17th handshake edge leaves all three at 0.
//   5. Reset mid-DRIVE: rst_n low one cycle after accept.
//      -> core_in=0, m_valid=0, counters unchanged at 0, s_ready=1 after release.
//   6. SETTLE_CYC=0: accept at E0 -> m_valid after E0+1 with the correct m_resp.

Source files
------------

// File: rtl/netlist_vector_player.sv
// netlist_vector_player
// Sequential driver/capture wrapper for a combinational core under evaluation.
// A stimulus vector is taken from the input stream and driven onto the core inputs.
// After a settle window the core outputs are sampled and compared against an expected
// word under a mask. The result goes out on the output stream, and pass/fail tallies
// are kept alongside it.

module netlist_vector_player #(
    parameter int IN_W       = 14,
    parameter int OUT_W      = 8,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // stimulus stream
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_stim,
    input  logic [OUT_W-1:0] s_expect,
    input  logic [OUT_W-1:0] s_mask,
    // core under evaluation
    output logic [IN_W-1:0]  core_in,
    input  logic [OUT_W-1:0] core_out,
    // result stream
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_resp,
    output logic             m_mismatch,
    output logic [CNT_W-1:0] m_idx,
    // tallies
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    input  logic             clear
);

    // The settle counter must be able to hold SETTLE_CYC. It keeps at least one bit so
    // that the SETTLE_CYC=0 build still has a legal vector.
    localparam int SC_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IN_W-1:0]  core_in_reg;
    logic [OUT_W-1:0] expect_reg;
    logic [OUT_W-1:0] mask_reg;
    logic [SC_W-1:0]  settle_reg;
    logic [OUT_W-1:0] m_resp_reg;
    logic             m_mismatch_reg;
    logic             m_valid_reg;
    logic             s_ready_reg;
    logic [CNT_W-1:0] m_idx_reg;
    logic [CNT_W-1:0] pass_cnt_reg;
    logic [CNT_W-1:0] fail_cnt_reg;

    logic [OUT_W-1:0] diff_bits;
    logic             mismatch_now;
    logic             result_taken;

    // Per-bit compare of the live core output against the latched expectation. Bits
    // with a zero mask drop out, so an all-zero mask can never report a mismatch.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_cmp
            assign diff_bits[gi] = (core_out[gi] ^ expect_reg[gi]) & mask_reg[gi];
        end
    endgenerate

    assign mismatch_now = |diff_bits;

    // The result leaves the block only on a REPORT handshake. m_valid_reg is high
    // exactly while the FSM is in REPORT.
    assign result_taken = m_valid_reg & m_ready;

    // Vector sequencing: accept, hold core_in for the settle window, capture, report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            core_in_reg    <= '0;
            expect_reg     <= '0;
            mask_reg       <= '0;
            settle_reg     <= '0;
            m_resp_reg     <= '0;
            m_mismatch_reg <= 1'b0;
            m_valid_reg    <= 1'b0;
            s_ready_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // core_in changes only here, so the core sees no stray edges.
                    if (s_valid) begin
                        core_in_reg <= s_stim;
                        expect_reg  <= s_expect;
                        mask_reg    <= s_mask;
                        settle_reg  <= SETTLE_LOAD;
                        s_ready_reg <= 1'b0;
                        state_reg   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settle_reg != '0) begin
                        settle_reg <= settle_reg - SC_W'(1);
                    end else begin
                        m_resp_reg     <= core_out;
                        m_mismatch_reg <= mismatch_now;
                        m_valid_reg    <= 1'b1;
                        state_reg      <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    // The result is held until the consumer takes it.
                    if (m_ready) begin
                        m_valid_reg <= 1'b0;
                        s_ready_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: begin
                    m_valid_reg <= 1'b0;
                    s_ready_reg <= 1'b1;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    // Sequence number and tallies. A clear overrides a coinciding handshake, so that
    // result is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx_reg    <= '0;
            pass_cnt_reg <= '0;
            fail_cnt_reg <= '0;
        end else if (clear) begin
            m_idx_reg    <= '0;
            pass_cnt_reg <= '0;
            fail_cnt_reg <= '0;
        end else if (result_taken) begin
            m_idx_reg <= m_idx_reg + CNT_W'(1);
            if (m_mismatch_reg) begin
                if (fail_cnt_reg != CNT_MAX) begin
                    fail_cnt_reg <= fail_cnt_reg + CNT_W'(1);
                end
            end else begin
                if (pass_cnt_reg != CNT_MAX) begin
                    pass_cnt_reg <= pass_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign s_ready    = s_ready_reg;
    assign core_in    = core_in_reg;
    assign m_valid    = m_valid_reg;
    assign m_resp     = m_resp_reg;
    assign m_mismatch = m_mismatch_reg;
    assign m_idx      = m_idx_reg;
    assign pass_cnt   = pass_cnt_reg;
    assign fail_cnt   = fail_cnt_reg;

endmodule

// File: tb/tb_netlist_vector_player.sv
// Testbench for netlist_vector_player. Three instances are exercised: the default
// build (0), a CNT_W=4 build (1) and a SETTLE_CYC=0 build (2). Each core is stubbed as
// core_out = core_in[7:0] ^ 8'hA5. A transaction-level model checks every instance
// on every falling edge, and directed scenarios pin literal expectations.

module tb_netlist_vector_player;

    logic clk;
    logic rst_n;

    logic [2:0]  s_valid;
    logic [2:0]  m_ready;
    logic [2:0]  clear;
    logic [13:0] s_stim [3];
    logic [7:0]  s_exp  [3];
    logic [7:0]  s_mask [3];

    wire  [2:0]  s_ready_w;
    wire  [2:0]  m_valid_w;
    wire  [2:0]  m_mis_w;
    wire  [13:0] core_in_w  [3];
    wire  [7:0]  core_out_w [3];
    wire  [7:0]  m_resp_w   [3];
    wire  [15:0] idx_w      [3];
    wire  [15:0] pass_w     [3];
    wire  [15:0] fail_w     [3];
    wire  [3:0]  idx1, pass1, fail1;

    int checks   = 0;
    int failures = 0;

    // Model configuration per instance.
    int s_of  [3] = '{2, 2, 0};
    int cw_of [3] = '{16, 4, 16};

    // Core stubs.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_core
            assign core_out_w[gi] = core_in_w[gi][7:0] ^ 8'hA5;
        end
    endgenerate

    netlist_vector_player #(.IN_W(14), .OUT_W(8), .SETTLE_CYC(2), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[0]), .s_ready(s_ready_w[0]), .s_stim(s_stim[0]),
        .s_expect(s_exp[0]), .s_mask(s_mask[0]),
        .core_in(core_in_w[0]), .core_out(core_out_w[0]),
        .m_valid(m_valid_w[0]), .m_ready(m_ready[0]), .m_resp(m_resp_w[0]),
        .m_mismatch(m_mis_w[0]), .m_idx(idx_w[0]),
        .pass_cnt(pass_w[0]), .fail_cnt(fail_w[0]), .clear(clear[0])
    );

    netlist_vector_player #(.IN_W(14), .OUT_W(8), .SETTLE_CYC(2), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[1]), .s_ready(s_ready_w[1]), .s_stim(s_stim[1]),
        .s_expect(s_exp[1]), .s_mask(s_mask[1]),
        .core_in(core_in_w[1]), .core_out(core_out_w[1]),
        .m_valid(m_valid_w[1]), .m_ready(m_ready[1]), .m_resp(m_resp_w[1]),
        .m_mismatch(m_mis_w[1]), .m_idx(idx1),
        .pass_cnt(pass1), .fail_cnt(fail1), .clear(clear[1])
    );

    assign idx_w[1]  = {12'd0, idx1};
    assign pass_w[1] = {12'd0, pass1};
    assign fail_w[1] = {12'd0, fail1};

    netlist_vector_player #(.IN_W(14), .OUT_W(8), .SETTLE_CYC(0), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[2]), .s_ready(s_ready_w[2]), .s_stim(s_stim[2]),
        .s_expect(s_exp[2]), .s_mask(s_mask[2]),
        .core_in(core_in_w[2]), .core_out(core_out_w[2]),
        .m_valid(m_valid_w[2]), .m_ready(m_ready[2]), .m_resp(m_resp_w[2]),
        .m_mismatch(m_mis_w[2]), .m_idx(idx_w[2]),
        .pass_cnt(pass_w[2]), .fail_cnt(fail_w[2]), .clear(clear[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0h required=%0h time=%0t", nm, inst, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A vector accepted on edge E is reported from edge E+S+1 until its handshake.
    // Between vectors the block is ready. Counters follow plain modular and
    // saturating arithmetic.
    longint      cyc = 0;
    bit          md_busy [3];
    longint      md_vat  [3];
    logic [13:0] md_core [3];
    logic [7:0]  md_resp [3];
    logic        md_mis  [3];
    longint      md_idx  [3];
    longint      md_pass [3];
    longint      md_fail [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            longint maxv;
            bit     exp_valid;
            maxv = (longint'(1) << cw_of[i]) - 1;
            if (!rst_n) begin
                md_busy[i] = 1'b0;
                md_core[i] = '0;
                md_idx[i]  = 0;
                md_pass[i] = 0;
                md_fail[i] = 0;
                chk("rst_core_in", i, 32'(core_in_w[i]), 32'h0);
                chk("rst_m_valid", i, 32'(m_valid_w[i]), 32'h0);
                chk("rst_m_resp", i, 32'(m_resp_w[i]), 32'h0);
                chk("rst_m_mismatch", i, 32'(m_mis_w[i]), 32'h0);
                chk("rst_m_idx", i, 32'(idx_w[i]), 32'h0);
                chk("rst_pass_cnt", i, 32'(pass_w[i]), 32'h0);
                chk("rst_fail_cnt", i, 32'(fail_w[i]), 32'h0);
            end else begin
                exp_valid = md_busy[i] && (cyc >= md_vat[i]);
                chk("s_ready", i, 32'(s_ready_w[i]), 32'(!md_busy[i]));
                chk("m_valid", i, 32'(m_valid_w[i]), 32'(exp_valid));
                chk("core_in", i, 32'(core_in_w[i]), 32'(md_core[i]));
                chk("m_idx", i, 32'(idx_w[i]), 32'(md_idx[i]));
                chk("pass_cnt", i, 32'(pass_w[i]), 32'(md_pass[i]));
                chk("fail_cnt", i, 32'(fail_w[i]), 32'(md_fail[i]));
                if (exp_valid) begin
                    chk("m_resp", i, 32'(m_resp_w[i]), 32'(md_resp[i]));
                    chk("m_mismatch", i, 32'(m_mis_w[i]), 32'(md_mis[i]));
                end
                // Work out what the coming rising edge does.
                if (exp_valid && m_ready[i]) begin
                    md_busy[i] = 1'b0;
                    if (!clear[i]) begin
                        md_idx[i] = (md_idx[i] + 1) % (maxv + 1);
                        if (md_mis[i]) begin
                            if (md_fail[i] < maxv) md_fail[i] = md_fail[i] + 1;
                        end else begin
                            if (md_pass[i] < maxv) md_pass[i] = md_pass[i] + 1;
                        end
                    end
                end else if (!md_busy[i] && s_valid[i]) begin
                    md_busy[i] = 1'b1;
                    md_core[i] = s_stim[i];
                    md_resp[i] = s_stim[i][7:0] ^ 8'hA5;
                    md_mis[i]  = (((s_stim[i][7:0] ^ 8'hA5) ^ s_exp[i]) & s_mask[i]) != 8'h00;
                    md_vat[i]  = cyc + 1 + s_of[i] + 1;
                end
                if (clear[i]) begin
                    md_idx[i]  = 0;
                    md_pass[i] = 0;
                    md_fail[i] = 0;
                end
            end
        end
        cyc++;
    end

    // ---------------- driver ----------------
    // Sends one vector and waits for its result. lat counts the edges from the
    // accept edge E0 (0) to the edge after which m_valid is first seen. The consumer
    // then stalls for rdly cycles before accepting. clr pulses clear on the
    // handshake edge.
    task automatic send(input int i, input logic [13:0] st, input logic [7:0] ex,
                        input logic [7:0] mk, input int rdly, input bit clr,
                        output int lat, output logic [7:0] resp, output logic mis,
                        output logic [15:0] idx);
        int k;
        s_stim[i]  = st;
        s_exp[i]   = ex;
        s_mask[i]  = mk;
        s_valid[i] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!s_ready_w[i] && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (!s_ready_w[i]) chk("accept_timeout", i, 32'(s_ready_w[i]), 32'h1);
        @(posedge clk);
        #1;
        s_valid[i] = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!m_valid_w[i] && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        if (!m_valid_w[i]) chk("result_timeout", i, 32'(m_valid_w[i]), 32'h1);
        resp = m_resp_w[i];
        mis  = m_mis_w[i];
        idx  = idx_w[i];
        for (int r = 0; r < rdly; r++) begin
            @(negedge clk);
            chk("hold_m_valid", i, 32'(m_valid_w[i]), 32'h1);
            chk("hold_m_resp", i, 32'(m_resp_w[i]), 32'(resp));
            chk("hold_m_idx", i, 32'(idx_w[i]), 32'(idx));
            chk("hold_s_ready", i, 32'(s_ready_w[i]), 32'h0);
        end
        @(posedge clk);
        #1;
        m_ready[i] = 1'b1;
        clear[i]   = clr;
        @(posedge clk);
        #1;
        m_ready[i] = 1'b0;
        clear[i]   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          lat;
        logic [7:0]  resp;
        logic        mis;
        logic [15:0] idx;
        logic [13:0] st;
        logic [7:0]  ex;
        logic [7:0]  mk;

        rst_n   = 1'b0;
        s_valid = '0;
        m_ready = '0;
        clear   = '0;
        for (int i = 0; i < 3; i++) begin
            s_stim[i] = '0;
            s_exp[i]  = '0;
            s_mask[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // SETTLE_CYC=0: the result is visible right after the edge that follows the accept.
        send(2, 14'h0012, 8'hB7, 8'hFF, 0, 1'b0, lat, resp, mis, idx);
        chk("s0_latency", 2, 32'(lat), 32'd1);
        chk("s0_resp", 2, 32'(resp), 32'hB7);
        chk("s0_mismatch", 2, 32'(mis), 32'h0);

        // Latency with the default settle window.
        send(0, 14'h0012, 8'hB7, 8'hFF, 0, 1'b0, lat, resp, mis, idx);
        chk("lat_latency", 0, 32'(lat), 32'd3);
        chk("lat_resp", 0, 32'(resp), 32'hB7);
        chk("lat_mismatch", 0, 32'(mis), 32'h0);
        chk("lat_idx", 0, 32'(idx), 32'h0);
        chk("lat_pass_after", 0, 32'(pass_w[0]), 32'd1);
        chk("lat_idx_after", 0, 32'(idx_w[0]), 32'd1);

        // Mask behaviour.
        send(0, 14'h0012, 8'hB6, 8'hFF, 0, 1'b0, lat, resp, mis, idx);
        chk("mask_ff_mismatch", 0, 32'(mis), 32'h1);
        chk("mask_ff_fail", 0, 32'(fail_w[0]), 32'd1);
        send(0, 14'h0012, 8'hB6, 8'hFE, 0, 1'b0, lat, resp, mis, idx);
        chk("mask_fe_mismatch", 0, 32'(mis), 32'h0);
        send(0, 14'h0012, 8'h00, 8'h00, 0, 1'b0, lat, resp, mis, idx);
        chk("mask_zero_mismatch", 0, 32'(mis), 32'h0);

        // Backpressure: the result is held for 5 cycles and counted once.
        send(0, 14'h1F3C, 8'h99, 8'hFF, 5, 1'b0, lat, resp, mis, idx);
        chk("bp_resp", 0, 32'(resp), 32'h99);
        chk("bp_idx", 0, 32'(idx), 32'd4);
        chk("bp_pass_after", 0, 32'(pass_w[0]), 32'd4);
        chk("bp_fail_after", 0, 32'(fail_w[0]), 32'd1);
        chk("bp_idx_after", 0, 32'(idx_w[0]), 32'd5);

        // Saturation and wrap on the 4-bit build, with clear on the 17th handshake.
        for (int n = 0; n < 16; n++) begin
            st = 14'($urandom);
            send(1, st, st[7:0] ^ 8'hA5, 8'hFF, 0, 1'b0, lat, resp, mis, idx);
        end
        chk("sat_pass", 1, 32'(pass_w[1]), 32'hF);
        chk("sat_idx", 1, 32'(idx_w[1]), 32'h0);
        send(1, 14'h0012, 8'hB7, 8'hFF, 0, 1'b1, lat, resp, mis, idx);
        chk("wrap_idx17", 1, 32'(idx), 32'h0);
        chk("clr_pass", 1, 32'(pass_w[1]), 32'h0);
        chk("clr_fail", 1, 32'(fail_w[1]), 32'h0);
        chk("clr_idx", 1, 32'(idx_w[1]), 32'h0);

        // Randomized traffic on every instance.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 40; n++) begin
                st = 14'($urandom);
                ex = ($urandom_range(0, 1) == 0) ? (st[7:0] ^ 8'hA5) : 8'($urandom);
                case ($urandom_range(0, 3))
                    0:       mk = 8'h00;
                    1:       mk = 8'hFF;
                    default: mk = 8'($urandom);
                endcase
                send(i, st, ex, mk, $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                     lat, resp, mis, idx);
                chk("rand_latency", i, 32'(lat), 32'(s_of[i] + 1));
                chk("rand_resp", i, 32'(resp), 32'(st[7:0] ^ 8'hA5));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        // Reset one cycle after an accept drops the vector.
        do_reset();
        s_stim[0]  = 14'h0033;
        s_exp[0]   = 8'h96;
        s_mask[0]  = 8'hFF;
        s_valid[0] = 1'b1;
        @(negedge clk);
        chk("mid_ready_before", 0, 32'(s_ready_w[0]), 32'h1);
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        chk("mid_core_in_driven", 0, 32'(core_in_w[0]), 32'h0033);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_core_in", 0, 32'(core_in_w[0]), 32'h0);
        chk("mid_m_valid", 0, 32'(m_valid_w[0]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_s_ready_after", 0, 32'(s_ready_w[0]), 32'h1);
        chk("mid_pass_after", 0, 32'(pass_w[0]), 32'h0);
        chk("mid_fail_after", 0, 32'(fail_w[0]), 32'h0);
        chk("mid_idx_after", 0, 32'(idx_w[0]), 32'h0);
        repeat (6) @(negedge clk);
        chk("mid_no_result", 0, 32'(m_valid_w[0]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
